// File: rtl/perf_pkg.sv
// Shared limits and helpers for the performance-counter block.
package perf_pkg;

  localparam int MAX_EVENTS = 16;
  localparam int MIN_CNT_W  = 8;
  localparam int MAX_CNT_W  = 64;

  // Bits needed to encode 0..n (n event channels plus the cycle channel).
  function automatic int clog2_sel(input int n);
    int w;
    w = 1;
    while ((1 << w) < (n + 1)) w++;
    return w;
  endfunction

endpackage

// File: rtl/perf_event_counter.sv
// One counter channel: edge/level qualify, wrap or saturate, sticky overflow.
module perf_event_counter #(
  parameter int CNT_WIDTH = 32,
  parameter bit EDGE      = 1'b0,
  parameter bit SATURATE  = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 evt_i,
  input  logic                 clr_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 ovf_o
);

  logic                 prev_q;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 inc;

  always_comb begin
    inc   = en_i & evt_i & (~EDGE | ~prev_q);
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc) begin
      if (&cnt_q) begin
        ovf_d = 1'b1;
        cnt_d = SATURATE ? cnt_q : '0;
      end else begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  // prev tracks the raw strobe every cycle so edges seen while disabled are consumed.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      prev_q <= evt_i;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/perf_counter_unit.sv
// Event/cycle performance monitor with atomic snapshot bank and registered indexed read.
module perf_counter_unit import perf_pkg::*; #(
  parameter int                    NUM_EVENTS = 4,
  parameter int                    CNT_WIDTH  = 32,
  parameter logic [NUM_EVENTS-1:0] EDGE_MASK  = '0,
  parameter bit                    SATURATE   = 1'b0,
  parameter int                    SEL_W      = clog2_sel(NUM_EVENTS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  freeze_i,
  input  logic [NUM_EVENTS-1:0] event_i,
  input  logic                  clear_i,
  input  logic                  snapshot_i,
  input  logic                  rd_en_i,
  input  logic [SEL_W-1:0]      rd_sel_i,
  output logic [CNT_WIDTH-1:0]  rd_data_o,
  output logic                  rd_valid_o,
  output logic [NUM_EVENTS:0]   overflow_o
);

  localparam int NCH = NUM_EVENTS + 1;
  // Top channel is the cycle counter: always-on strobe, level mode.
  localparam logic [NCH-1:0] EDGE_ALL = {1'b0, EDGE_MASK};

  logic                          en;
  logic [NCH-1:0]                evt_all;
  logic [NCH-1:0][CNT_WIDTH-1:0] live;
  logic [NCH-1:0][CNT_WIDTH-1:0] shadow_q, shadow_d;
  logic [CNT_WIDTH-1:0]          rd_mux;
  logic [CNT_WIDTH-1:0]          rd_data_q, rd_data_d;
  logic                          rd_valid_q, rd_valid_d;

  assign en      = start_i & ~freeze_i;
  assign evt_all = {1'b1, event_i};

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    perf_event_counter #(
      .CNT_WIDTH(CNT_WIDTH),
      .EDGE     (EDGE_ALL[k]),
      .SATURATE (SATURATE)
    ) u_cnt (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .en_i (en),
      .evt_i(evt_all[k]),
      .clr_i(clear_i),
      .cnt_o(live[k]),
      .ovf_o(overflow_o[k])
    );
  end

  always_comb begin
    shadow_d = snapshot_i ? live : shadow_q;
    rd_mux   = '0;
    for (int k = 0; k < NCH; k++)
      if (rd_sel_i == SEL_W'(k)) rd_mux = shadow_q[k];
    rd_data_d  = rd_en_i ? rd_mux : rd_data_q;
    rd_valid_d = rd_en_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      shadow_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: tb/tb_perf_counter_unit.sv
// Directed bench: wrapping and saturating instances driven in lockstep.
module tb_perf_counter_unit;

  localparam int NE = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, freeze, clear, snapshot, rd_en;
  logic [NE-1:0] ev;
  logic [2:0]    rd_sel;
  logic [CW-1:0] rd_data, rd_data_s;
  logic          rd_valid, rd_valid_s;
  logic [NE:0]   ovf, ovf_s;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  perf_counter_unit #(.NUM_EVENTS(NE), .CNT_WIDTH(CW), .EDGE_MASK(4'b0010), .SATURATE(1'b0)) dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .freeze_i(freeze), .event_i(ev),
    .clear_i(clear), .snapshot_i(snapshot), .rd_en_i(rd_en), .rd_sel_i(rd_sel),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid), .overflow_o(ovf));

  perf_counter_unit #(.NUM_EVENTS(NE), .CNT_WIDTH(CW), .EDGE_MASK(4'b0010), .SATURATE(1'b1)) dut_s (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .freeze_i(freeze), .event_i(ev),
    .clear_i(clear), .snapshot_i(snapshot), .rd_en_i(rd_en), .rd_sel_i(rd_sel),
    .rd_data_o(rd_data_s), .rd_valid_o(rd_valid_s), .overflow_o(ovf_s));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [2:0] sel, output logic [CW-1:0] d,
                         output logic [CW-1:0] ds, output logic v);
    rd_en  = 1'b1;
    rd_sel = sel;
    tick();
    rd_en = 1'b0;
    d     = rd_data;
    ds    = rd_data_s;
    v     = rd_valid;
  endtask

  task automatic snap();
    snapshot = 1'b1;
    tick();
    snapshot = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    logic [CW-1:0] d, ds;
    logic v;
    start = 1'b1; ev = 4'b0001;
    repeat (5) tick();
    snap();
    start = 1'b0; ev = '0;
    do_read(3'd4, d, ds, v);
    checks++;
    if (d !== 8'd5 || v !== 1'b1) begin
      failures++;
      $display("FAIL reset_precount: got data=%0d valid=%b, need data=5 valid=1", d, v);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rd_data !== '0 || rd_valid !== 1'b0 || ovf !== '0) begin
      failures++;
      $display("FAIL reset_async: got data=%0d valid=%b ovf=%b, need all 0", rd_data, rd_valid, ovf);
    end
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    snap();
    for (int s = 0; s <= NE; s++) begin
      do_read(3'(s), d, ds, v);
      checks++;
      if (d !== '0 || v !== 1'b1) begin
        failures++;
        $display("FAIL reset_read sel=%0d: got data=%0d valid=%b, need data=0 valid=1", s, d, v);
      end
    end
  endtask

  task automatic test_level_edge();
    logic [CW-1:0] d, ds;
    logic v;
    logic [CW-1:0] exp_v [0:4];
    exp_v = '{8'd5, 8'd1, 8'd0, 8'd0, 8'd6};
    do_clear();
    start = 1'b1; ev = '0;
    tick();
    ev = 4'b0011;
    repeat (5) tick();
    start = 1'b0; ev = '0;
    snap();
    for (int s = 0; s <= NE; s++) begin
      do_read(3'(s), d, ds, v);
      checks++;
      if (d !== exp_v[s] || v !== 1'b1) begin
        failures++;
        $display("FAIL level_edge sel=%0d: got %0d valid=%b, need %0d", s, d, v, exp_v[s]);
      end
    end
  endtask

  task automatic test_freeze();
    logic [CW-1:0] d, ds;
    logic v;
    do_clear();
    start = 1'b1; freeze = 1'b0; ev = 4'b0110;
    repeat (3) tick();
    freeze = 1'b1; ev = 4'b0100;
    tick();
    ev = 4'b0110;
    repeat (3) tick();
    freeze = 1'b0;
    repeat (2) tick();
    start = 1'b0; ev = '0;
    snap();
    do_read(3'd2, d, ds, v);
    checks++;
    if (d !== 8'd5) begin
      failures++;
      $display("FAIL freeze_level: got %0d, need 5", d);
    end
    do_read(3'd1, d, ds, v);
    checks++;
    if (d !== 8'd1) begin
      failures++;
      $display("FAIL freeze_edge: got %0d, need 1", d);
    end
    do_read(3'd4, d, ds, v);
    checks++;
    if (d !== 8'd5) begin
      failures++;
      $display("FAIL freeze_cycle: got %0d, need 5", d);
    end
  endtask

  task automatic test_overflow();
    logic [CW-1:0] d, ds;
    logic v;
    do_clear();
    start = 1'b1; ev = 4'b0001;
    repeat (255) tick();
    checks++;
    if (ovf[0] !== 1'b0 || ovf_s[0] !== 1'b0) begin
      failures++;
      $display("FAIL ovf_at_255: got wrap=%b sat=%b, need 0 0", ovf[0], ovf_s[0]);
    end
    repeat (2) tick();
    start = 1'b0; ev = '0;
    snap();
    checks++;
    if (ovf[0] !== 1'b1 || ovf_s[0] !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sticky: got wrap=%b sat=%b, need 1 1", ovf[0], ovf_s[0]);
    end
    do_read(3'd0, d, ds, v);
    checks++;
    if (d !== 8'd1) begin
      failures++;
      $display("FAIL ovf_wrap_count: got %0d, need 1", d);
    end
    checks++;
    if (ds !== 8'd255) begin
      failures++;
      $display("FAIL ovf_sat_count: got %0d, need 255", ds);
    end
    do_clear();
    checks++;
    if (ovf !== '0 || ovf_s !== '0) begin
      failures++;
      $display("FAIL ovf_clear: got wrap=%b sat=%b, need 0", ovf, ovf_s);
    end
    snap();
    do_read(3'd0, d, ds, v);
    checks++;
    if (d !== '0 || ds !== '0) begin
      failures++;
      $display("FAIL ovf_clear_count: got wrap=%0d sat=%0d, need 0 0", d, ds);
    end
  endtask

  task automatic test_read_clear();
    logic [CW-1:0] d, ds;
    logic v;
    do_clear();
    start = 1'b1; ev = 4'b0001;
    repeat (7) tick();
    ev = '0;
    repeat (13) tick();
    // event high in the clear cycle must not survive the clear
    ev = 4'b0001; snapshot = 1'b1; clear = 1'b1;
    tick();
    snapshot = 1'b0; clear = 1'b0; start = 1'b0; ev = '0;
    do_read(3'd0, d, ds, v);
    checks++;
    if (d !== 8'd7) begin
      failures++;
      $display("FAIL rdclr_ch0: got %0d, need 7", d);
    end
    do_read(3'd4, d, ds, v);
    checks++;
    if (d !== 8'd20) begin
      failures++;
      $display("FAIL rdclr_cycle: got %0d, need 20", d);
    end
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    snap();
    do_read(3'd4, d, ds, v);
    checks++;
    if (d !== 8'd3) begin
      failures++;
      $display("FAIL rdclr_after_cycle: got %0d, need 3", d);
    end
    do_read(3'd0, d, ds, v);
    checks++;
    if (d !== 8'd0) begin
      failures++;
      $display("FAIL rdclr_after_ch0: got %0d, need 0", d);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]    sel_v [0:2];
    logic [CW-1:0] exp_v [0:2];
    sel_v = '{3'd0, 3'd5, 3'd4};
    exp_v = '{8'd2, 8'd0, 8'd4};
    do_clear();
    start = 1'b1; ev = 4'b0001;
    repeat (2) tick();
    ev = '0;
    repeat (2) tick();
    start = 1'b0;
    snap();
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd_sel = sel_v[i];
      tick();
      checks++;
      if (rd_data !== exp_v[i] || rd_valid !== 1'b1) begin
        failures++;
        $display("FAIL b2b_read%0d sel=%0d: got data=%0d valid=%b, need data=%0d valid=1",
                 i, sel_v[i], rd_data, rd_valid, exp_v[i]);
      end
    end
    rd_en = 1'b0;
    tick();
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 8'd4) begin
      failures++;
      $display("FAIL read_hold: got data=%0d valid=%b, need data=4 valid=0", rd_data, rd_valid);
    end
    rd_en = 1'b1; rd_sel = 3'd7;
    tick();
    rd_en = 1'b0;
    checks++;
    if (rd_data !== 8'd0 || rd_valid !== 1'b1) begin
      failures++;
      $display("FAIL read_sel7: got data=%0d valid=%b, need data=0 valid=1", rd_data, rd_valid);
    end
    start = 1'b1;
    repeat (2) tick();
    start = 1'b0;
    snapshot = 1'b1; rd_en = 1'b1; rd_sel = 3'd4;
    tick();
    snapshot = 1'b0;
    checks++;
    if (rd_data !== 8'd4) begin
      failures++;
      $display("FAIL snap_read_same: got %0d, need old 4", rd_data);
    end
    tick();
    rd_en = 1'b0;
    checks++;
    if (rd_data !== 8'd6 || rd_valid !== 1'b1) begin
      failures++;
      $display("FAIL snap_read_next: got data=%0d valid=%b, need 6 valid=1", rd_data, rd_valid);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; freeze = 1'b0; clear = 1'b0; snapshot = 1'b0;
    rd_en = 1'b0; ev = '0; rd_sel = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_level_edge();
    test_freeze();
    test_overflow();
    test_read_clear();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
